regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file; the next-generation replacement for the datapath's single-write, two-read 64x32 register file. Configurable data width, depth and read-port count, plus two write ports with fixed priority. Adds a synchronous-reset clear sweep with a ready indication, and optional write-to-read bypass. Sits between decode (read addresses) and writeback (ALU and load write ports) in the RISC-V datapath.

## Interface
Parameters:
- XLEN, 64, data width in bits.
- DEPTH, 32, number of registers; power of two, 2 to 256.
- NUM_READ, 2, number of read ports, 1 to 4.
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes.

Derived constant: AW = clog2(DEPTH).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- ready  output  1  high when the clear sweep is done and the file accepts writes.
- we0  input  1  write enable, port 0 (ALU writeback).
- waddr0  input  AW  write address, port 0.
- wdata0  input  XLEN  write data, port 0.
- we1  input  1  write enable, port 1 (load writeback); wins over port 0 on an address collision.
- waddr1  input  AW  write address, port 1.
- wdata1  input  XLEN  write data, port 1.
- raddr  input  NUM_READ*AW  read addresses, flattened; port k is bits [k*AW +: AW].
- rdata  output  NUM_READ*XLEN  read data, flattened; port k is bits [k*XLEN +: XLEN]; combinational.

## Operation
- The FSM has two states: CLEAR and RUN.
- When rst is high at a clock edge:
  - state goes to CLEAR, ptr goes to 0 and ready goes to 0.
  - No array write happens on that edge.
- CLEAR state:
  - Each cycle writes 0 to entry ptr, then ptr increments.
  - When ptr == DEPTH-1, the final entry is written and state goes to RUN on the same edge.
  - The sweep therefore takes exactly DEPTH cycles after rst is released.
  - we0 and we1 are ignored.
  - Every rdata lane reads 0.
- rst asserted mid-sweep restarts the sweep from ptr = 0.
- RUN state, write ports:
  - ready = 1.
  - The write on port n happens when wen is high, and also waddrn != 0 if ZERO_REG is 1.
  - If both ports write the same address, wdata1 is stored.
  - If the addresses differ, both are stored on the same edge.
- RUN state, read ports:
  - Each rdata lane k = array[raddr_k].
  - With ZERO_REG = 1, raddr_k == 0 returns 0 regardless of array contents.
- Address width is exact (AW bits), so no out-of-range addresses exist.
- ptr is AW+1 bits wide to avoid wrap ambiguity at DEPTH = 256.

## Timing
- Reset values: ready = 0, state = CLEAR, ptr = 0. rdata is 0 while in CLEAR.
- ready rises DEPTH cycles after the first cycle with rst low.
- Write latency: 1 cycle. Data written at edge N is visible on rdata after edge N.
- A read of an address being written in the same cycle:
  - Without bypass, it returns the old value.
  - With bypass, see Configuration.
- No handshake on the write ports. The writeback stage must hold we0 and we1 low, or accept loss, while ready = 0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In RUN, rdata lane k returns wdata1 if we1 is high and waddr1 == raddr_k.
  - Otherwise it returns wdata0 if we0 is high and waddr0 == raddr_k.
  - Otherwise it returns array data.
  - Bypass follows the same port-1 priority and ZERO_REG masking; address 0 always reads 0.
  - Bypass is not active in CLEAR.
- REGFILE_BYPASS_EN undefined: reads return array contents only, with 1-cycle write-to-read latency.

## Structure
- Shared package (rv_pkg):
  - XLEN default.
  - Register-count default.
  - Register-state enum {RF_CLEAR, RF_RUN}.
- Sub-module regfile_read_mux: one read lane holding the address decode, zero mask and bypass select. It is instantiated NUM_READ times by a generate loop.
- The array, write logic and sweep FSM live in regfile_mp.

## Test plan
- Reset and sweep:
  - Pulse rst for 1 cycle with DEPTH = 32.
  - ready stays 0 for exactly 32 cycles, then goes 1.
  - Every address reads 0 afterwards.
  - Writes issued during the sweep are not stored.
- Basic write and read:
  - we0 = 1, waddr0 = 5, wdata0 = 64'hDEAD_BEEF_0000_0001.
  - rdata lane 0 with raddr = 5 shows the value on the next cycle. Without bypass it shows the old value (0) in the same cycle.
- Collision:
  - we0 and we1 both high at address 7, wdata0 = 1, wdata1 = 2.
  - Address 7 reads 2.
  - Separately, addresses 3 and 4 written in the same cycle both hold their data.
- Zero register:
  - Write 64'hFFFF_FFFF_FFFF_FFFF to address 0 on both ports.
  - Every read lane at address 0 returns 0, with and without REGFILE_BYPASS_EN.
- Bypass (REGFILE_BYPASS_EN, NUM_READ = 3):
  - we1 writes 9 to address 12 while all three lanes read address 12.
  - All lanes show 9 in the same cycle.
- Reset mid-sweep:
  - Assert rst at sweep cycle 10 for 1 cycle.
  - ready rises exactly DEPTH cycles after the second release.
  - Entries written before the first reset read 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared datapath package: default widths and register-file state encoding.
package rv_pkg;

  localparam int XLEN_DEF      = 64;
  localparam int REG_COUNT_DEF = 32;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_read_mux.sv
// One register-file read lane: zero-register mask, CLEAR-state masking and,
// when REGFILE_BYPASS_EN is defined, write-to-read forwarding with port-1 priority.
module regfile_read_mux #(
  parameter int XLEN     = 64,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            run,
  input  logic [AW-1:0]   raddr,
  input  logic [XLEN-1:0] arr_data,
`ifdef REGFILE_BYPASS_EN
  input  logic            we0,
  input  logic [AW-1:0]   waddr0,
  input  logic [XLEN-1:0] wdata0,
  input  logic            we1,
  input  logic [AW-1:0]   waddr1,
  input  logic [XLEN-1:0] wdata1,
`endif
  output logic [XLEN-1:0] rdata
);

  logic masked;

  assign masked = !run || ((ZERO_REG != 0) && (raddr == '0));

  // Port 1 is checked last so it overrides port 0 when both hit this address.
  always_comb begin
    rdata = '0;
    if (!masked) begin
      rdata = arr_data;
`ifdef REGFILE_BYPASS_EN
      if (we0 && (waddr0 == raddr)) rdata = wdata0;
      if (we1 && (waddr1 == raddr)) rdata = wdata1;
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a reset-time clear sweep and two prioritised write ports.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
  import rv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int DEPTH    = REG_COUNT_DEF,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic                     we0,
  input  logic [AW-1:0]            waddr0,
  input  logic [XLEN-1:0]          wdata0,
  input  logic                     we1,
  input  logic [AW-1:0]            waddr1,
  input  logic [XLEN-1:0]          wdata1,
  input  logic [NUM_READ*AW-1:0]   raddr,
  output logic [NUM_READ*XLEN-1:0] rdata
);

  localparam logic [AW:0] PTR_LAST = (AW+1)'(DEPTH - 1);

  rf_state_t       state;
  logic [AW:0]     ptr;
  logic [XLEN-1:0] mem [DEPTH];
  logic            wr0;
  logic            wr1;
  logic            run;

  assign run = (state == RF_RUN);
  assign wr0 = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign wr1 = we1 && !((ZERO_REG != 0) && (waddr1 == '0));

  // Array is not reset directly; the CLEAR sweep zeroes one entry per cycle.
  // In RUN, port 1's assignment comes last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_CLEAR;
      ptr   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        RF_CLEAR: begin
          mem[ptr[AW-1:0]] <= '0;
          ptr              <= ptr + 1'b1;
          if (ptr == PTR_LAST) begin
            state <= RF_RUN;
            ready <= 1'b1;
          end
        end
        RF_RUN: begin
          if (wr0) mem[waddr0] <= wdata0;
          if (wr1) mem[waddr1] <= wdata1;
        end
        default: begin
          state <= RF_CLEAR;
          ptr   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [XLEN-1:0] arr_data;

    assign arr_data = mem[raddr[k*AW +: AW]];

    regfile_read_mux #(
      .XLEN     (XLEN),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_read_mux (
      .run      (run),
      .raddr    (raddr[k*AW +: AW]),
      .arr_data (arr_data),
`ifdef REGFILE_BYPASS_EN
      .we0      (we0),
      .waddr0   (waddr0),
      .wdata0   (wdata0),
      .we1      (we1),
      .waddr1   (waddr1),
      .wdata1   (wdata1),
`endif
      .rdata    (rdata[k*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (DEPTH=32, three read lanes), randomized
// traffic against an array model; follows REGFILE_BYPASS_EN when it is defined.
module tb_regfile_mp;

  localparam int XLEN     = 64;
  localparam int DEPTH    = 32;
  localparam int NUM_READ = 3;
  localparam int AW       = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     ready;
  logic                     we0, we1;
  logic [AW-1:0]            waddr0, waddr1;
  logic [XLEN-1:0]          wdata0, wdata1;
  logic [AW-1:0]            ra [NUM_READ];
  logic [NUM_READ*AW-1:0]   raddr;
  logic [NUM_READ*XLEN-1:0] rdata;

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0] m_mem [DEPTH];
  int              m_cleared = 0;

  assign raddr = {ra[2], ra[1], ra[0]};

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .NUM_READ (NUM_READ),
    .ZERO_REG (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ready  (ready),
    .we0    (we0),
    .waddr0 (waddr0),
    .wdata0 (wdata0),
    .we1    (we1),
    .waddr1 (waddr1),
    .wdata1 (wdata1),
    .raddr  (raddr),
    .rdata  (rdata)
  );

  function automatic logic m_ready();
    return m_cleared == DEPTH;
  endfunction

  // Expected read value from the current inputs and the model array.
  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (!m_ready() || a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we1 && waddr1 == a) return wdata1;
    if (we0 && waddr0 == a) return wdata0;
`endif
    return m_mem[a];
  endfunction

  // Advance the model by one clock edge, then let the DUT take the same edge.
  task automatic tick();
    if (rst) begin
      m_cleared = 0;
    end else if (m_cleared < DEPTH) begin
      m_mem[m_cleared] = '0;
      m_cleared++;
    end else begin
      if (we0 && waddr0 != '0) m_mem[waddr0] = wdata0;
      if (we1 && waddr1 != '0) m_mem[waddr1] = wdata1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_writes();
    we0 = 1'b0; we1 = 1'b0;
    waddr0 = '0; waddr1 = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  task automatic random_writes();
    we0    = 1'($urandom_range(0, 1));
    we1    = 1'($urandom_range(0, 1));
    waddr0 = AW'($urandom_range(0, DEPTH - 1));
    waddr1 = AW'($urandom_range(0, DEPTH - 1));
    wdata0 = {$urandom, $urandom};
    wdata1 = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    idle_writes();
    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < NUM_READ; k++) ra[k] = AW'(k + 1);
    #1;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_ready got=%b want=0", ready);
    end
    for (int k = 0; k < NUM_READ; k++) begin
      total++;
      if (rdata[k*XLEN +: XLEN] !== '0) begin
        bad++;
        $display("[TB] FAIL reset_rdata lane=%0d got=%h want=0", k, rdata[k*XLEN +: XLEN]);
      end
    end
    rst = 1'b0;
    // Writes during the sweep must be dropped.
    for (int i = 0; i < DEPTH; i++) begin
      random_writes();
      #1;
      total++;
      if (ready !== m_ready()) begin
        bad++;
        $display("[TB] FAIL sweep_ready cycle=%0d got=%b want=%b", i, ready, m_ready());
      end
      tick();
    end
    idle_writes();
    #1;
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sweep_done_ready got=%b want=1", ready);
    end
    for (int a = 0; a < DEPTH; a++) begin
      for (int k = 0; k < NUM_READ; k++) ra[k] = AW'((a + k) % DEPTH);
      #1;
      for (int k = 0; k < NUM_READ; k++) begin
        total++;
        if (rdata[k*XLEN +: XLEN] !== 64'd0) begin
          bad++;
          $display("[TB] FAIL sweep_zero addr=%0d lane=%0d got=%h want=0", ra[k], k, rdata[k*XLEN +: XLEN]);
        end
      end
    end
  endtask

  task automatic test_basic();
    idle_writes();
    we0 = 1'b1; waddr0 = 5; wdata0 = 64'hDEAD_BEEF_0000_0001;
    ra[0] = 5; ra[1] = 6; ra[2] = 0;
    #1;
    total++;
    if (rdata[0 +: XLEN] !== exp_rd(5)) begin
      bad++;
      $display("[TB] FAIL basic_same_cycle got=%h want=%h", rdata[0 +: XLEN], exp_rd(5));
    end
    tick();
    idle_writes();
    #1;
    total++;
    if (rdata[0 +: XLEN] !== 64'hDEAD_BEEF_0000_0001) begin
      bad++;
      $display("[TB] FAIL basic_next_cycle got=%h want=deadbeef00000001", rdata[0 +: XLEN]);
    end
  endtask

  task automatic test_collision();
    idle_writes();
    we0 = 1'b1; waddr0 = 7; wdata0 = 64'd1;
    we1 = 1'b1; waddr1 = 7; wdata1 = 64'd2;
    tick();
    waddr0 = 3; wdata0 = 64'h3333;
    waddr1 = 4; wdata1 = 64'h4444;
    tick();
    idle_writes();
    ra[0] = 7; ra[1] = 3; ra[2] = 4;
    #1;
    total++;
    if (rdata[0 +: XLEN] !== 64'd2) begin
      bad++;
      $display("[TB] FAIL collision_prio got=%h want=2", rdata[0 +: XLEN]);
    end
    total++;
    if (rdata[XLEN +: XLEN] !== 64'h3333) begin
      bad++;
      $display("[TB] FAIL dual_write_a got=%h want=3333", rdata[XLEN +: XLEN]);
    end
    total++;
    if (rdata[2*XLEN +: XLEN] !== 64'h4444) begin
      bad++;
      $display("[TB] FAIL dual_write_b got=%h want=4444", rdata[2*XLEN +: XLEN]);
    end
  endtask

  task automatic test_zero_reg();
    idle_writes();
    we0 = 1'b1; waddr0 = 0; wdata0 = '1;
    we1 = 1'b1; waddr1 = 0; wdata1 = '1;
    for (int k = 0; k < NUM_READ; k++) ra[k] = 0;
    for (int pass = 0; pass < 2; pass++) begin
      #1;
      for (int k = 0; k < NUM_READ; k++) begin
        total++;
        if (rdata[k*XLEN +: XLEN] !== 64'd0) begin
          bad++;
          $display("[TB] FAIL zero_reg pass=%0d lane=%0d got=%h want=0", pass, k, rdata[k*XLEN +: XLEN]);
        end
      end
      tick();
      idle_writes();
    end
  endtask

  task automatic test_bypass();
    idle_writes();
    we1 = 1'b1; waddr1 = 12; wdata1 = 64'd9;
    for (int k = 0; k < NUM_READ; k++) ra[k] = 12;
    #1;
    for (int k = 0; k < NUM_READ; k++) begin
      total++;
      if (rdata[k*XLEN +: XLEN] !== exp_rd(12)) begin
        bad++;
        $display("[TB] FAIL bypass_same_cycle lane=%0d got=%h want=%h", k, rdata[k*XLEN +: XLEN], exp_rd(12));
      end
    end
    tick();
    idle_writes();
    #1;
    total++;
    if (rdata[0 +: XLEN] !== 64'd9) begin
      bad++;
      $display("[TB] FAIL bypass_after got=%h want=9", rdata[0 +: XLEN]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      random_writes();
      for (int k = 0; k < NUM_READ; k++) begin
        // Bias reads toward the write targets so bypass and collisions get exercised.
        case ($urandom_range(0, 3))
          0:       ra[k] = waddr0;
          1:       ra[k] = waddr1;
          default: ra[k] = AW'($urandom_range(0, DEPTH - 1));
        endcase
      end
      #1;
      for (int k = 0; k < NUM_READ; k++) begin
        total++;
        if (rdata[k*XLEN +: XLEN] !== exp_rd(ra[k])) begin
          bad++;
          $display("[TB] FAIL random cyc=%0d lane=%0d addr=%0d got=%h want=%h",
                   i, k, ra[k], rdata[k*XLEN +: XLEN], exp_rd(ra[k]));
        end
      end
      tick();
    end
    idle_writes();
  endtask

  task automatic test_mid_reset();
    for (int a = 1; a < DEPTH; a++) begin
      idle_writes();
      we0 = 1'b1; waddr0 = AW'(a); wdata0 = {$urandom, $urandom} | 64'd1;
      tick();
    end
    idle_writes();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      total++;
      if (ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL mid_reset_ready_early cycle=%0d got=%b want=0", i, ready);
      end
      tick();
    end
    #1;
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_reset_ready got=%b want=1", ready);
    end
    for (int a = 0; a < DEPTH; a += NUM_READ) begin
      for (int k = 0; k < NUM_READ; k++) ra[k] = AW'((a + k) % DEPTH);
      #1;
      for (int k = 0; k < NUM_READ; k++) begin
        total++;
        if (rdata[k*XLEN +: XLEN] !== 64'd0) begin
          bad++;
          $display("[TB] FAIL mid_reset_clear addr=%0d got=%h want=0", ra[k], rdata[k*XLEN +: XLEN]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_writes();
    for (int k = 0; k < NUM_READ; k++) ra[k] = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_collision();
    test_zero_reg();
    test_bypass();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
